// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             wclk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge wclk) begin
    if (wclken) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock show-ahead FIFO with registered full/empty flags.
// Optional status outputs (wcount, almost flags, sticky over/underflow) under FIFO_STATUS_EN.
module sync_fifo_core
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
`ifdef FIFO_STATUS_EN
  ,
  output logic [ASIZE:0]   wcount,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PW = ptr_width(ASIZE);

  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [PW-1:0]    wptr_next_s;
  logic [PW-1:0]    rptr_next_s;
  logic             wfull_r;
  logic             rempty_r;
  logic             write_en_s;
  logic             read_en_s;
  logic [DSIZE-1:0] mem_rdata_s;

  // Acceptance uses the current registered flags.
  always_comb begin
    write_en_s  = winc & ~wfull_r;
    read_en_s   = rinc & ~rempty_r;
    wptr_next_s = wptr_r + {{(PW-1){1'b0}}, write_en_s};
    rptr_next_s = rptr_r + {{(PW-1){1'b0}}, read_en_s};
  end

  // Pointers and flags; flags derive from next-state pointers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      wfull_r  <= 1'b0;
      rempty_r <= 1'b1;
    end else begin
      wptr_r   <= wptr_next_s;
      rptr_r   <= rptr_next_s;
      rempty_r <= (wptr_next_s == rptr_next_s);
      wfull_r  <= (wptr_next_s == {~rptr_next_s[ASIZE], rptr_next_s[ASIZE-1:0]});
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .wclk   (wclk),
    .wclken (write_en_s),
    .waddr  (wptr_r[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rptr_r[ASIZE-1:0]),
    .rdata  (mem_rdata_s)
  );

  // Show-ahead data, forced to zero while empty.
  always_comb begin
    if (rempty_r) begin
      rdata = '0;
    end else begin
      rdata = mem_rdata_s;
    end
  end

  assign wfull  = wfull_r;
  assign rempty = rempty_r;

`ifdef FIFO_STATUS_EN
  localparam int DEPTH = depth_of(ASIZE);

  logic [PW-1:0] count_next_s;
  logic [PW-1:0] wcount_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic          overflow_r;
  logic          underflow_r;

  assign count_next_s = wptr_next_s - rptr_next_s;

  // Occupancy-derived status and sticky error bits, cleared only by reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wcount_r       <= '0;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      wcount_r       <= count_next_s;
      almost_full_r  <= (count_next_s >= PW'(DEPTH - 1));
      almost_empty_r <= (count_next_s <= PW'(1));
      overflow_r     <= overflow_r | (winc & wfull_r);
      underflow_r    <= underflow_r | (rinc & rempty_r);
    end
  end

  assign wcount       = wcount_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core: queue reference model plus directed and random traffic.
module tb_sync_fifo_core;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             wclk;
  logic             wrst_n;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
`ifdef FIFO_STATUS_EN
  logic [ASIZE:0]   wcount;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] q[$];
  logic             ovf_m;
  logic             udf_m;

  sync_fifo_core #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
`ifdef FIFO_STATUS_EN
    ,
    .wcount       (wcount),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: occupancy is the queue length; acceptance from pre-edge occupancy.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      q.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      automatic bit w_ok = winc && (q.size() < DEPTH);
      automatic bit r_ok = rinc && (q.size() > 0);
      if (winc && q.size() == DEPTH) ovf_m = 1'b1;
      if (rinc && q.size() == 0) udf_m = 1'b1;
      if (r_ok) void'(q.pop_front());
      if (w_ok) q.push_back(wdata);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge wclk) begin
    chk("rempty", {31'd0, rempty}, {31'd0, q.size() == 0});
    chk("wfull", {31'd0, wfull}, {31'd0, q.size() == DEPTH});
    chk("rdata", {24'd0, rdata}, (q.size() == 0) ? 32'd0 : {24'd0, q[0]});
`ifdef FIFO_STATUS_EN
    chk("wcount", {27'd0, wcount}, q.size());
    chk("almost_full", {31'd0, almost_full}, {31'd0, q.size() >= DEPTH - 1});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, q.size() <= 1});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    chk("underflow", {31'd0, underflow}, {31'd0, udf_m});
`endif
  end

  task automatic step(input logic w, input logic r, input logic [DSIZE-1:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge wclk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b1;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    #1 wrst_n = 1'b0;
    #20;
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    chk("reset_rempty", {31'd0, rempty}, 32'd1);
    chk("reset_wfull", {31'd0, wfull}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("idle_rempty", {31'd0, rempty}, 32'd1);

    // Fill
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 0) chk("fill_first_rempty", {31'd0, rempty}, 32'd0);
      if (i == DEPTH - 2) chk("fill_15_wfull", {31'd0, wfull}, 32'd0);
    end
    chk("fill_wfull", {31'd0, wfull}, 32'd1);
    step(1'b1, 1'b0, 8'hAA);
    chk("over_wfull", {31'd0, wfull}, 32'd1);
    chk("over_head", {24'd0, rdata}, 32'h00);

    // Drain
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", {24'd0, rdata}, i);
      step(1'b0, 1'b1, 8'h00);
      if (i == 0) chk("drain_first_wfull", {31'd0, wfull}, 32'd0);
    end
    chk("drain_rempty", {31'd0, rempty}, 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("under_rdata", {24'd0, rdata}, 32'd0);
    chk("under_rempty", {31'd0, rempty}, 32'd1);

    // Wrap across address rollover
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("wrap_wfull", {31'd0, wfull}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("wrap_data", {24'd0, rdata}, 32'h20 + i);
      step(1'b0, 1'b1, 8'h00);
    end
    chk("wrap_rempty", {31'd0, rempty}, 32'd1);

    // Simultaneous read and write
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
    chk("simul_head", {24'd0, rdata}, 32'h53);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    chk("simul_full", {31'd0, wfull}, 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    chk("full_both_wfull", {31'd0, wfull}, 32'd0);
    chk("full_both_head", {24'd0, rdata}, 32'h54);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00);
    chk("empty_again", {31'd0, rempty}, 32'd1);
    step(1'b1, 1'b1, 8'h77);
    chk("empty_both_rempty", {31'd0, rempty}, 32'd0);
    chk("empty_both_rdata", {24'd0, rdata}, 32'h77);
    step(1'b0, 1'b1, 8'h00);

    // Reset mid-burst
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
    wrst_n = 1'b0;
    #1;
    chk("midrst_rempty", {31'd0, rempty}, 32'd1);
    chk("midrst_wfull", {31'd0, wfull}, 32'd0);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    step(1'b1, 1'b0, 8'h55);
    chk("postrst_rdata", {24'd0, rdata}, 32'h55);

    // Randomized traffic with varying bias
    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 500) % 3;
      automatic logic w = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      automatic logic r = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      step(w, r, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock first-in/first-out buffer with show-ahead read data and registered full/empty status. Written words are stored in a 2^ASIZE-entry dual-port memory. Read data is presented combinationally from the head entry. The block sits between a producer and a consumer sharing one clock and buffers bursts of up to DEPTH words.

Parameters:
DSIZE, 8, data word width in bits
ASIZE, 4, address width; DEPTH = 2^ASIZE entries (default 16)

Ports:
wclk  input  1  sole clock; all state updates on rising edge
wrst_n  input  1  reset, asynchronous assert, active-low
wdata  input  DSIZE  write data, sampled when a write is accepted
winc  input  1  write request
rinc  input  1  read request (pop head entry)
rdata  output  DSIZE  head-of-FIFO data (show-ahead)
wfull  output  1  FIFO holds DEPTH words
rempty  output  1  FIFO holds zero words

Behaviour:
- One clock (wclk); reset wrst_n is asynchronous, active-low; deassertion is released synchronously to wclk by the integrating logic.
- State: write pointer wptr and read pointer rptr, each ASIZE+1 bits binary. Memory address = low ASIZE bits. The MSB is the wrap bit.
- Reset: wptr=0, rptr=0, wfull=0, rempty=1, rdata=0. Memory contents are not cleared.
- Write accepted when winc=1 and wfull=0. On that edge: mem[waddr] <= wdata and wptr increments.
- Read accepted when rinc=1 and rempty=0. On that edge rptr increments.
- winc while full and rinc while empty are ignored. Pointers and memory are unchanged, and no error is raised in the base build.
- Flags are registered and computed from next-state pointers, so they update on the same edge as the accepting write or read.
  - rempty_next = (wptr_next == rptr_next)
  - wfull_next = (wptr_next == {~rptr_next[ASIZE], rptr_next[ASIZE-1:0]})
- rdata = mem[raddr] when rempty=0, else 0.
  - Data is combinational from the registered rptr (zero read latency).
  - A word written on edge N is visible on rdata after edge N once rempty has dropped.
- Simultaneous accepted read and write: both pointers advance and the occupancy and flags are unchanged.
- Simultaneous requests while full: the read is accepted and the write is dropped, because acceptance uses the current wfull.
- Simultaneous requests while empty: the write is accepted and the read is dropped.
- Pointer wrap: binary increment rolls over modulo 2^(ASIZE+1). The wrap bit toggles every DEPTH operations.
- Reset mid-operation: pointers and flags return to reset values immediately (asynchronous) and pending requests are discarded.

Optional Feature:
Macro FIFO_STATUS_EN.
- Defined, adds outputs:
  - wcount [ASIZE:0]: registered occupancy, wptr−rptr.
  - almost_full: occupancy ≥ DEPTH−1.
  - almost_empty: occupancy ≤ 1.
  - overflow: sticky; set by winc while wfull.
  - underflow: sticky; set by rinc while rempty.
  - All five reset to 0, except almost_empty which resets to 1. The sticky bits clear only on reset.
- Undefined: these ports and their logic are absent, and base behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default DSIZE/ASIZE constants
  - DEPTH localparam function
  - pointer-type width helper (ASIZE+1)
- One sub-module, fifo_mem: DEPTH×DSIZE storage with synchronous write port (wclken, waddr, wdata) and asynchronous read port (raddr → rdata).
- Pointer and flag logic stays in sync_fifo_core.

Test Plan:
- Reset: assert wrst_n=0 for 20 ns -> rempty=1, wfull=0, rdata=0; release with no requests -> flags unchanged.
- Fill: write 0x00..0x0F on 16 consecutive edges -> rempty falls after the first write, wfull=1 after the 16th; a 17th write of 0xAA is ignored.
- Drain: from full, assert rinc for 16 edges -> rdata shows 0x00,0x01,…,0x0F in order, wfull falls after the first read, rempty=1 after the 16th; a 17th rinc is ignored and rdata=0.
- Wrap: write 10, read 10, write 16 (0x20..0x2F), read 16 -> data in order, flags correct across the address rollover.
- Simultaneous: at occupancy 5, winc=rinc=1 for 8 edges -> occupancy stays 5 and order is preserved. On full with both asserted -> read taken, write dropped, wfull=0 next. On empty with both asserted -> write taken, rempty=0 next.
- Reset mid-burst: after 7 writes, pulse wrst_n low -> rempty=1, wfull=0 immediately; a subsequent write of 0x55 appears on rdata next cycle.
